gf_mul_sched: RTL

GF_MUL_SCHED -- requirements
Module: gf_mul_sched

---
 rtl/gf_mul_pkg.sv | 18 +
 rtl/gf_res_fifo.sv | 65 ++++++
 rtl/gf_mul_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gf_mul_pkg.sv
// Shared definitions for the GF multiplier scheduler: state encoding and parameter defaults.
package gf_mul_pkg;

  localparam int LAT_DEF   = 7;
  localparam int HOLD_DEF  = 1;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  // Width of a counter that holds values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf_res_fifo.sv
// Result buffer: shift-register FIFO whose head is itself a register, so dout/empty/full
// come straight from flops.
module gf_res_fifo
  import gf_mul_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = 32,
  parameter int CW    = cnt_width(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  data_q [DEPTH];
  logic [W-1:0]  data_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && !full_q;

  always_comb begin
    data_d = data_q;
    wr_idx = cnt_q - CW'(do_pop);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
      data_d[DEPTH-1] = '0;
    end
    // Write lands just behind the last valid entry after any shift.
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) data_d[i] = din_i;
      end
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign dout_o  = data_q[0];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/gf_mul_sched.sv
// Issue scheduler for an external GF(2^32) multiplier array; results return in order via a FIFO.
// Optional performance counters are enabled by defining GF_MUL_SCHED_PERF_EN.
module gf_mul_sched
  import gf_mul_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_g,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_p,
  output logic [31:0] arr_ai,
  output logic [31:0] arr_bi,
  output logic [31:0] arr_gi,
  output logic        arr_ctr,
  input  logic [31:0] arr_po
`ifdef GF_MUL_SCHED_PERF_EN
  ,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall
`endif
);

  localparam int HW = cnt_width(HOLD);
  localparam int CW = cnt_width(DEPTH + 1);

  state_e          state_q;
  logic [HW-1:0]   hold_q;
  logic            ctr_q;
  logic [31:0]     ai_q, bi_q, gi_q;
  logic [LAT-1:0]  tok_q, tok_d;
  logic [CW-1:0]   total_q, total_d;
  logic            last_slot, credit_ok, accept, pop, push;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign last_slot = (state_q == ISSUE) && (hold_q == '0);
  assign credit_ok = total_q < CW'(DEPTH);
  // Gating with rst keeps ready low while reset is held, whatever state the flops are in.
  assign req_ready = rst && credit_ok && ((state_q == IDLE) || last_slot);
  assign accept    = req_valid && req_ready;
  assign pop       = res_valid && res_ready;
  assign push      = tok_q[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ctr_q   <= 1'b0;
      ai_q    <= '0;
      bi_q    <= '0;
      gi_q    <= '0;
    end else begin
      ctr_q <= accept;
      if (accept) begin
        state_q <= ISSUE;
        hold_q  <= HW'(HOLD - 1);
        ai_q    <= req_a;
        bi_q    <= req_b;
        gi_q    <= req_g;
      end else if (state_q == ISSUE) begin
        if (hold_q != '0) begin
          hold_q <= hold_q - 1'b1;
        end else begin
          state_q <= IDLE;
          ai_q    <= '0;
          bi_q    <= '0;
          gi_q    <= '0;
        end
      end
    end
  end

  always_comb begin
    tok_d    = tok_q << 1;
    tok_d[0] = ctr_q;
    total_d  = total_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tok_q   <= '0;
      total_q <= '0;
    end else begin
      tok_q   <= tok_d;
      total_q <= total_d;
    end
  end

  gf_res_fifo #(
    .DEPTH (DEPTH),
    .W     (32),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst),
    .push_i  (push),
    .din_i   (arr_po),
    .pop_i   (res_ready),
    .dout_o  (res_p),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign arr_ai    = ai_q;
  assign arr_bi    = bi_q;
  assign arr_gi    = gi_q;
  assign arr_ctr   = ctr_q;

  // Credit accounting must make overflow impossible; buffered results never exceed the credit total.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && fifo_full)) else $error("gf_mul_sched: push into full result fifo");
      assert (fifo_count <= total_q) else $error("gf_mul_sched: fifo occupancy exceeds credit total");
    end
  end

`ifdef GF_MUL_SCHED_PERF_EN
  logic [15:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop && (perf_ops_q != 16'hFFFF)) perf_ops_q <= perf_ops_q + 16'd1;
      if (req_valid && !req_ready && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
